// File: rtl/simon_datapath_pkg.sv
// Simon game datapath shared definitions.
// Sizes of the pattern memory and the one-hot legality helper.
package simon_datapath_pkg;

    localparam int DATA_W = 4;
    localparam int DEPTH  = 64;
    localparam int ADDR_W = $clog2(DEPTH);

    // Exactly one bit set; zero is not one-hot.
    function automatic logic is_one_hot(input logic [DATA_W-1:0] p);
        return (p != '0) && ((p & (p - DATA_W'(1))) == '0);
    endfunction

endpackage

// File: rtl/simon_datapath_mem.sv
// Simon sequence storage.
// DEPTH x DATA_W array, synchronous write, asynchronous read.
module simon_mem #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Store one pattern entry; contents survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/simon_datapath.sv
// Simon game datapath: sequence memory, index and end pointer.
// Status flags feed the controller FSM; LEDs show switches or sequence.
module simon_datapath
    import simon_datapath_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              level,
    input  logic [DATA_W-1:0] pattern,
    input  logic              last_inc,
    input  logic              i_inc,
    input  logic              i_clr,
    input  logic              mem_ld,
    input  logic              s_led_eq_pat,
    output logic              i_lt_last,
    output logic              arr_full,
    output logic              correct_pat,
    output logic              legal,
    output logic [DATA_W-1:0] pattern_leds
);

    localparam logic [ADDR_W-1:0] LAST_MAX = ADDR_W'(DEPTH - 1);

    logic              mode;
    logic [ADDR_W-1:0] i;
    logic [ADDR_W-1:0] last;
    logic [ADDR_W-1:0] i_nxt;
    logic [ADDR_W-1:0] last_nxt;
    logic [DATA_W-1:0] mem_rd;
    logic              i_wrap;
    logic              mem_we;

    assign i_wrap = (i == last);
    assign mem_we = mem_ld & ~rst;

    // Index next state: clear beats increment; increment wraps at last.
    always_comb begin
        i_nxt = i;
        unique case (1'b1)
            i_clr:                     i_nxt = '0;
            !i_clr && i_inc && i_wrap:  i_nxt = '0;
            !i_clr && i_inc && !i_wrap: i_nxt = i + ADDR_W'(1);
            default:                   i_nxt = i;
        endcase
    end

    // End pointer saturates at the final entry instead of wrapping.
    always_comb begin
        last_nxt = last;
        if (last_inc && !arr_full) begin
            last_nxt = last + ADDR_W'(1);
        end
    end

    // Mode is only latched on reset; index and pointer restart at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode <= level;
            i    <= '0;
            last <= '0;
        end else begin
            i    <= i_nxt;
            last <= last_nxt;
        end
    end

    simon_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (last),
        .wdata (pattern),
        .raddr (i),
        .rdata (mem_rd)
    );

    // Status flags and LED mux, all combinational.
    always_comb begin
        i_lt_last    = (i < last);
        arr_full     = (last == LAST_MAX);
        correct_pat  = (pattern == mem_rd);
        legal        = mode | is_one_hot(pattern);
        pattern_leds = s_led_eq_pat ? pattern : mem_rd;
    end

endmodule

// File: tb/tb_simon_datapath.sv
// Self-checking bench for simon_datapath.
// Directed scenarios plus random traffic against a behavioural model.
module tb_simon_datapath;
    import simon_datapath_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              level;
    logic [DATA_W-1:0] pattern;
    logic              last_inc;
    logic              i_inc;
    logic              i_clr;
    logic              mem_ld;
    logic              s_led_eq_pat;
    logic              i_lt_last;
    logic              arr_full;
    logic              correct_pat;
    logic              legal;
    logic [DATA_W-1:0] pattern_leds;

    int errors = 0;
    int checks = 0;

    bit m_mode;
    int m_i;
    int m_last;
    int m_mem [DEPTH];
    bit m_known [DEPTH];

    simon_datapath dut (
        .clk          (clk),
        .rst          (rst),
        .level        (level),
        .pattern      (pattern),
        .last_inc     (last_inc),
        .i_inc        (i_inc),
        .i_clr        (i_clr),
        .mem_ld       (mem_ld),
        .s_led_eq_pat (s_led_eq_pat),
        .i_lt_last    (i_lt_last),
        .arr_full     (arr_full),
        .correct_pat  (correct_pat),
        .legal        (legal),
        .pattern_leds (pattern_leds)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        rst      = 1'b0;
        last_inc = 1'b0;
        i_inc    = 1'b0;
        i_clr    = 1'b0;
        mem_ld   = 1'b0;
    endtask

    // One clock edge; the model applies the same inputs the DUT saw.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_i    = 0;
            m_last = 0;
            m_mode = level;
        end else begin
            if (mem_ld) begin
                m_mem[m_last]   = int'(pattern);
                m_known[m_last] = 1'b1;
            end
            if (i_clr) m_i = 0;
            else if (i_inc) m_i = (m_i == m_last) ? 0 : m_i + 1;
            if (last_inc && m_last < DEPTH - 1) m_last++;
        end
        #1;
    endtask

    task automatic check_model();
        logic exp_legal;
        exp_legal = m_mode ? 1'b1 : ($countones(pattern) == 1);
        check("m_i_lt_last", i_lt_last, m_i < m_last);
        check("m_arr_full", arr_full, m_last == DEPTH - 1);
        check("m_legal", legal, exp_legal);
        if (s_led_eq_pat)
            check("m_leds_sw", pattern_leds, pattern);
        else if (m_known[m_i])
            check("m_leds_mem", pattern_leds, m_mem[m_i]);
        if (m_known[m_i])
            check("m_correct", correct_pat, int'(pattern) == m_mem[m_i]);
    endtask

    initial begin
        for (int k = 0; k < DEPTH; k++) m_known[k] = 1'b0;
        idle();
        pattern      = '0;
        s_led_eq_pat = 1'b0;

        // 1: hard mode, everything legal, LEDs follow switches
        rst = 1'b1; level = 1'b1;
        tick();
        idle();
        #1;
        check("rst_i_lt_last", i_lt_last, 0);
        check("rst_arr_full", arr_full, 0);
        pattern = 4'b0001; #1;
        check("hard_legal_0001", legal, 1);
        pattern = 4'b1111; #1;
        check("hard_legal_1111", legal, 1);
        s_led_eq_pat = 1'b1; #1;
        check("leds_switch", pattern_leds, 4'b1111);
        check_model();

        // 2: store 1111 at 0 and read it back
        i_clr = 1'b1; mem_ld = 1'b1;
        tick();
        idle();
        s_led_eq_pat = 1'b0; #1;
        check("leds_mem0", pattern_leds, 4'b1111);
        check("t2_i_lt_last", i_lt_last, 0);
        pattern = 4'b0001; #1;
        check("t2_correct", correct_pat, 0);
        check("t2_arr_full", arr_full, 0);
        check_model();

        // 3: easy mode legality
        rst = 1'b1; level = 1'b0;
        tick();
        idle();
        pattern = 4'b1111; #1; check("easy_1111", legal, 0);
        pattern = 4'b0001; #1; check("easy_0001", legal, 1);
        pattern = 4'b0011; #1; check("easy_0011", legal, 0);
        pattern = 4'b0010; #1; check("easy_0010", legal, 1);
        pattern = 4'b0000; #1; check("easy_0000", legal, 0);

        // 4: two-entry sequence with an overwrite
        pattern = 4'b0001; mem_ld = 1'b1; tick();
        mem_ld = 1'b0; last_inc = 1'b1; tick();
        last_inc = 1'b0;
        pattern = 4'b0011; mem_ld = 1'b1; tick();
        pattern = 4'b0010; tick();
        idle(); #1;
        check("t4_i_lt_last", i_lt_last, 1);
        check("t4_leds0", pattern_leds, 4'b0001);
        i_inc = 1'b1; tick(); i_inc = 1'b0; #1;
        check("t4_i_lt_last1", i_lt_last, 0);
        check("t4_leds1", pattern_leds, 4'b0010);
        i_inc = 1'b1; tick(); i_inc = 1'b0;
        pattern = 4'b0001; #1;
        check("t4_wrap_correct", correct_pat, 1);
        check_model();

        // 5: continuous playback alternates, clear wins over inc
        i_inc = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("t5_alt", pattern_leds, (k % 2 == 0) ? 4'b0001 : 4'b0010);
            tick();
        end
        tick();
        i_clr = 1'b1; tick(); idle(); #1;
        check("t5_clr_wins", pattern_leds, 4'b0001);
        check("t5_i_lt_last", i_lt_last, 1);
        check_model();

        // 6: saturation of last, write uses old last, reset keeps memory
        rst = 1'b1; level = 1'b0; tick(); idle();
        pattern = 4'b0100; mem_ld = 1'b1; last_inc = 1'b1; tick();
        idle(); pattern = 4'b0001; #1;
        check("t6_old_last", pattern_leds, 4'b0100);
        last_inc = 1'b1;
        for (int k = 0; k < 61; k++) tick();
        #1;
        check("t6_not_full", arr_full, 0);
        tick(); #1;
        check("t6_full", arr_full, 1);
        tick(); tick(); #1;
        check("t6_still_full", arr_full, 1);
        check_model();
        idle();
        rst = 1'b1; tick(); idle(); #1;
        check("t6_rst_full", arr_full, 0);
        check("t6_rst_lt", i_lt_last, 0);
        check("t6_mem_kept", pattern_leds, 4'b0100);

        // random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rst          = ($urandom_range(0, 199) == 0);
            level        = 1'($urandom);
            last_inc     = ($urandom_range(0, 7) == 0);
            i_inc        = 1'($urandom);
            i_clr        = ($urandom_range(0, 9) == 0);
            mem_ld       = ($urandom_range(0, 2) == 0);
            s_led_eq_pat = 1'($urandom);
            pattern      = DATA_W'($urandom);
            #1;
            check_model();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
